// File: rtl/fifo_shadow_checker_pkg.sv
// Shared definitions for the FIFO shadow checker: err_vec field
// indices, checker FSM states and the number of compared fields.
package fifo_shadow_checker_pkg;

    localparam int NUM_FIELDS = 8;

    localparam int ERR_DOUT   = 0;
    localparam int ERR_WACK   = 1;
    localparam int ERR_OVF    = 2;
    localparam int ERR_UDF    = 3;
    localparam int ERR_FULL   = 4;
    localparam int ERR_EMPTY  = 5;
    localparam int ERR_AFULL  = 6;
    localparam int ERR_AEMPTY = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARM,
        ST_CHECK,
        ST_HALT
    } chk_state_e;

endpackage

// File: rtl/fifo_shadow_checker_if.sv
// Tap bundle of the observed FIFO pins: reset, requests, write/read data,
// registered status pulses and occupancy flags. master drives, slave observes.
interface fifo_shadow_checker_if #(
    parameter int FIFO_WIDTH = 16
) ();

    logic                  obs_rst_n;
    logic                  obs_wr_en;
    logic                  obs_rd_en;
    logic [FIFO_WIDTH-1:0] obs_data_in;
    logic [FIFO_WIDTH-1:0] obs_data_out;
    logic                  obs_wr_ack;
    logic                  obs_overflow;
    logic                  obs_underflow;
    logic                  obs_full;
    logic                  obs_empty;
    logic                  obs_almostfull;
    logic                  obs_almostempty;

    modport master (
        output obs_rst_n, obs_wr_en, obs_rd_en, obs_data_in,
        output obs_data_out, obs_wr_ack, obs_overflow, obs_underflow,
        output obs_full, obs_empty, obs_almostfull, obs_almostempty
    );

    modport slave (
        input obs_rst_n, obs_wr_en, obs_rd_en, obs_data_in,
        input obs_data_out, obs_wr_ack, obs_overflow, obs_underflow,
        input obs_full, obs_empty, obs_almostfull, obs_almostempty
    );

endinterface

// File: rtl/fifo_shadow_checker_model.sv
// Cycle-accurate reference FIFO. Inputs: clk, rst, FIFO reset/request/data
// taps. Outputs: expected data_out (+valid), status pulses and flags.
module fifo_shadow_model #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  obs_rst_n,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [FIFO_WIDTH-1:0] data_in,
    output logic [FIFO_WIDTH-1:0] exp_dout,
    output logic                  exp_dout_valid,
    output logic                  exp_wr_ack,
    output logic                  exp_overflow,
    output logic                  exp_underflow,
    output logic                  exp_full,
    output logic                  exp_empty,
    output logic                  exp_afull,
    output logic                  exp_aempty
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [PW-1:0] LAST_P  = PW'(FIFO_DEPTH - 1);

    logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [FIFO_WIDTH-1:0] dout_q, dout_d;
    logic                  dv_q, dv_d;
    logic                  wr_ack_q, wr_ack_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  full, empty, wr_fire, rd_fire;

    assign full    = (cnt_q == DEPTH_C);
    assign empty   = (cnt_q == '0);
    assign wr_fire = wr_en & ~full;
    assign rd_fire = rd_en & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        dv_d     = dv_q;
        wr_ack_d = wr_fire;
        ovf_d    = wr_en & full;
        udf_d    = rd_en & empty;
        if (wr_fire) begin
            wr_ptr_d = (wr_ptr_q == LAST_P) ? '0 : wr_ptr_q + PW'(1);
        end
        if (rd_fire) begin
            rd_ptr_d = (rd_ptr_q == LAST_P) ? '0 : rd_ptr_q + PW'(1);
            dout_d   = mem_q[rd_ptr_q];
            dv_d     = 1'b1;
        end
        // Simultaneous fire leaves occupancy unchanged.
        case ({wr_fire, rd_fire})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
        // FIFO reset: data_out keeps its value but is no longer trusted.
        if (!obs_rst_n) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            dv_d     = 1'b0;
            wr_ack_d = 1'b0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            dout_q   <= '0;
            dv_q     <= 1'b0;
            wr_ack_q <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
            dv_q     <= dv_d;
            wr_ack_q <= wr_ack_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && obs_rst_n && wr_fire) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign exp_dout       = dout_q;
    assign exp_dout_valid = dv_q;
    assign exp_wr_ack     = wr_ack_q;
    assign exp_overflow   = ovf_q;
    assign exp_underflow  = udf_q;
    assign exp_full       = full;
    assign exp_empty      = empty;
    assign exp_afull      = (cnt_q == DEPTH_C - CW'(1));
    assign exp_aempty     = (cnt_q == CW'(1));

endmodule

// File: rtl/fifo_shadow_checker.sv
// Shadow checker for a synchronous FIFO. Ports: clk, rst, stop_on_err, obs
// (FIFO taps); err_pulse, err_vec, first_err_vec, counts, halted.
module fifo_shadow_checker
    import fifo_shadow_checker_pkg::*;
#(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stop_on_err,
    fifo_shadow_checker_if.slave   obs,
    output logic                   err_pulse,
    output logic [NUM_FIELDS-1:0]  err_vec,
    output logic [NUM_FIELDS-1:0]  first_err_vec,
    output logic [CNT_W-1:0]       error_count,
    output logic [CNT_W-1:0]       correct_count,
    output logic                   halted
);

    logic [FIFO_WIDTH-1:0] exp_dout;
    logic exp_dv, exp_wack, exp_ovf, exp_udf;
    logic exp_full, exp_empty, exp_afull, exp_aempty;

    fifo_shadow_model #(
        .FIFO_WIDTH (FIFO_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_model (
        .clk            (clk),
        .rst            (rst),
        .obs_rst_n      (obs.obs_rst_n),
        .wr_en          (obs.obs_wr_en),
        .rd_en          (obs.obs_rd_en),
        .data_in        (obs.obs_data_in),
        .exp_dout       (exp_dout),
        .exp_dout_valid (exp_dv),
        .exp_wr_ack     (exp_wack),
        .exp_overflow   (exp_ovf),
        .exp_underflow  (exp_udf),
        .exp_full       (exp_full),
        .exp_empty      (exp_empty),
        .exp_afull      (exp_afull),
        .exp_aempty     (exp_aempty)
    );

    chk_state_e            state_q, state_d;
    logic [NUM_FIELDS-1:0] cmp;
    logic [NUM_FIELDS-1:0] err_vec_q, err_vec_d;
    logic [NUM_FIELDS-1:0] first_q, first_d;
    logic [CNT_W-1:0]      err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0]      ok_cnt_q, ok_cnt_d;
    logic                  pulse_q, pulse_d;

    always_comb begin
        cmp             = '0;
        cmp[ERR_DOUT]   = exp_dv & (obs.obs_data_out != exp_dout);
        cmp[ERR_WACK]   = obs.obs_wr_ack      != exp_wack;
        cmp[ERR_OVF]    = obs.obs_overflow    != exp_ovf;
        cmp[ERR_UDF]    = obs.obs_underflow   != exp_udf;
        cmp[ERR_FULL]   = obs.obs_full        != exp_full;
        cmp[ERR_EMPTY]  = obs.obs_empty       != exp_empty;
        cmp[ERR_AFULL]  = obs.obs_almostfull  != exp_afull;
        cmp[ERR_AEMPTY] = obs.obs_almostempty != exp_aempty;
    end

    always_comb begin
        state_d   = state_q;
        err_vec_d = err_vec_q;
        first_d   = first_q;
        err_cnt_d = err_cnt_q;
        ok_cnt_d  = ok_cnt_q;
        pulse_d   = 1'b0;
        unique case (state_q)
            ST_IDLE:  state_d = ST_ARM;
            ST_ARM:   state_d = ST_CHECK;
            ST_CHECK: begin
                pulse_d   = |cmp;
                err_vec_d = cmp;
                if (first_q == '0) begin
                    first_d = cmp;
                end
                if (|cmp) begin
                    if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
                    if (stop_on_err) state_d = ST_HALT;
                end else begin
                    if (ok_cnt_q != '1) ok_cnt_d = ok_cnt_q + CNT_W'(1);
                end
            end
            ST_HALT:  state_d = ST_HALT;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            err_vec_q <= '0;
            first_q   <= '0;
            err_cnt_q <= '0;
            ok_cnt_q  <= '0;
            pulse_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            err_vec_q <= err_vec_d;
            first_q   <= first_d;
            err_cnt_q <= err_cnt_d;
            ok_cnt_q  <= ok_cnt_d;
            pulse_q   <= pulse_d;
        end
    end

    assign err_pulse     = pulse_q;
    assign err_vec       = err_vec_q;
    assign first_err_vec = first_q;
    assign error_count   = err_cnt_q;
    assign correct_count = ok_cnt_q;
    assign halted        = (state_q == ST_HALT);

endmodule
